axi4_lite_slave_endpoint: RTL and testbench
===========================================

// Module: axi4_lite_slave_endpoint
// PURPOSE
//  Synthesizable AXI4-Lite slave endpoint. Terminates the five AXI4-Lite channels and exposes
//  write and read transactions on a simple valid/ready user port. The user supplies write
//  responses and read data. Write and read paths are independent and may be active concurrently.
// PARAMETERS
//  DATA_BYTES  4  data bus width in bytes (wdata/rdata = DATA_BYTES*8, wstrb = DATA_BYTES)
//  ADDR_BYTES  1  address width in bytes (awaddr/araddr = ADDR_BYTES*8)
// PORTS
//  aclk     in   1     single clock; all logic on rising edge
//  areset   in   1     asynchronous, active-high reset
//  awvalid/awready in/out 1; awaddr in AW; awprot in 3          write address channel
//  wvalid/wready   in/out 1; wdata  in DW; wstrb  in DATA_BYTES write data channel
//  bvalid/bready   out/in 1; bresp  out 2                       write response channel
//  arvalid/arready in/out 1; araddr in AW; arprot in 3          read address channel
//  rvalid/rready   out/in 1; rdata  out DW; rresp out 2         read data channel
//  wr_valid out 1; wr_ready in 1; wr_addr out AW; wr_prot out 3; wr_data out DW; wr_strb out DATA_BYTES
//  wr_resp  in  2      write response, sampled on wr_valid&&wr_ready
//  rd_valid out 1; rd_ready in 1; rd_addr out AW; rd_prot out 3
//  rd_data  in  DW; rd_resp in 2   sampled on rd_valid&&rd_ready
// BEHAVIOUR
//  - All outputs registered. During and after reset: every output 0 (including ready signals).
//    Handshake readys assert from the first edge after reset release.
//  - Response codes: 00 OKAY, 01 EXOKAY, 10 SLVERR, 11 DECERR; passed through unmodified.
//  - Write FSM W_IDLE -> W_USER -> W_RESP -> W_IDLE:
//    W_IDLE: awready=1 until AW captured, wready=1 until W captured. AW and W may arrive in
//    either order or on the same edge. Each ready drops the edge after its own capture.
//    Both captured -> W_USER: wr_valid=1 with the captured addr/prot/data/strb (strb unmodified).
//    On wr_ready: latch wr_resp into bresp, drop wr_valid, go to W_RESP with bvalid=1.
//    On bready: bvalid=0, re-enable awready/wready, go to W_IDLE.
//  - Read FSM R_IDLE -> R_USER -> R_RESP -> R_IDLE:
//    R_IDLE: arready=1. On arvalid, capture araddr/arprot, drop arready, go to R_USER, rd_valid=1.
//    On rd_ready: latch rd_data/rd_resp into rdata/rresp, go to R_RESP with rvalid=1.
//    On rready: rvalid=0, go to R_IDLE with arready=1.
//  - Latency: AW+W at edge N -> wr_valid high after N. wr_ready at N+1 -> bvalid after N+1.
//    Reads have the same latency.
//  - Once asserted, bvalid/rvalid/wr_valid/rd_valid and their payloads stay stable until the handshake.
//  - One outstanding write and one outstanding read at a time; no AXI-side back-to-back overlap.
//  - No address decode or alignment check; addresses are passed through verbatim.
//  - Reset mid-transaction: in-flight transactions are discarded. All FSMs return to IDLE and all
//    outputs are cleared immediately (asynchronous).
// STRUCTURE
//  - Package axi4_lite_pkg: resp_t enum (OKAY/EXOKAY/SLVERR/DECERR); write and read FSM state enums.
//  - Write and read paths are two independent always_ff blocks in this module; no sub-modules.
// TESTING
//  1. AW=0xC4 and W=0xDEADBEEF/strb 0xF on the same cycle; wr_resp=01
//     -> wr_addr=0xC4, wr_data=0xDEADBEEF, bresp=01, one bvalid pulse.
//  2. AR=0xC4; user rd_data=0x0000ABCD, rd_resp=00 -> rdata=0x0000ABCD, rresp=00.
//  3. W sent 3 cycles before AW; strb=0x5 -> wr_valid only after AW; wr_strb=0x5.
//  4. bready and rready held low 5 cycles -> bvalid/rvalid and payloads stable; awready/arready stay 0.
//  5. Write and read issued on the same cycle -> both complete independently with correct data.
//  6. areset asserted while bvalid=1 -> all outputs 0 at once; a fresh write after release completes.

Source files
------------

// File: rtl/axi4_lite_slave_endpoint_pkg.sv
// Shared types for the AXI4-Lite slave endpoint: response codes and the
// write/read FSM state encodings.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_USER = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_USER = 2'd1,
    R_RESP = 2'd2
  } r_state_t;

endpackage

// File: rtl/axi4_lite_slave_endpoint_if.sv
// Bundle of the five AXI4-Lite channels plus the user-side write/read port.
// The slave modport is the endpoint's view; master is the environment's view
// (AXI master driving requests and user logic answering them).
interface axi4_lite_slave_endpoint_if #(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_BYTES = 1
);
  localparam int DW = DATA_BYTES * 8;
  localparam int AW = ADDR_BYTES * 8;

  logic                  awvalid, awready;
  logic [AW-1:0]         awaddr;
  logic [2:0]            awprot;
  logic                  wvalid, wready;
  logic [DW-1:0]         wdata;
  logic [DATA_BYTES-1:0] wstrb;
  logic                  bvalid, bready;
  logic [1:0]            bresp;
  logic                  arvalid, arready;
  logic [AW-1:0]         araddr;
  logic [2:0]            arprot;
  logic                  rvalid, rready;
  logic [DW-1:0]         rdata;
  logic [1:0]            rresp;

  logic                  wr_valid, wr_ready;
  logic [AW-1:0]         wr_addr;
  logic [2:0]            wr_prot;
  logic [DW-1:0]         wr_data;
  logic [DATA_BYTES-1:0] wr_strb;
  logic [1:0]            wr_resp;
  logic                  rd_valid, rd_ready;
  logic [AW-1:0]         rd_addr;
  logic [2:0]            rd_prot;
  logic [DW-1:0]         rd_data;
  logic [1:0]            rd_resp;

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
           wr_ready, wr_resp, rd_ready, rd_data, rd_resp,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
           wr_valid, wr_addr, wr_prot, wr_data, wr_strb,
           rd_valid, rd_addr, rd_prot
  );

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
           wr_ready, wr_resp, rd_ready, rd_data, rd_resp,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
           wr_valid, wr_addr, wr_prot, wr_data, wr_strb,
           rd_valid, rd_addr, rd_prot
  );
endinterface

// File: rtl/axi4_lite_slave_endpoint.sv
// AXI4-Lite slave endpoint. Terminates AW/W/B and AR/R, hands each write and
// read to user logic over a valid/ready port and returns the user's response.
// Write and read paths are independent FSMs; every output is a flop.
module axi4_lite_slave_endpoint
  import axi4_lite_pkg::*;
#(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_BYTES = 1
) (
  input  logic                        aclk,
  input  logic                        areset,
  axi4_lite_slave_endpoint_if.slave   bus
);
  localparam int DW = DATA_BYTES * 8;
  localparam int AW = ADDR_BYTES * 8;

  // ---------------- write path state ----------------
  w_state_t              w_state_q, w_state_d;
  logic                  awready_q, wready_q, aw_got_q, w_got_q;
  logic                  wr_valid_q, bvalid_q;
  logic [AW-1:0]         wr_addr_q;
  logic [2:0]            wr_prot_q;
  logic [DW-1:0]         wr_data_q;
  logic [DATA_BYTES-1:0] wr_strb_q;
  resp_t                 bresp_q;
  logic                  aw_fire_s, w_fire_s, aw_have_s, w_have_s;

  // ---------------- read path state ----------------
  r_state_t              r_state_q, r_state_d;
  logic                  arready_q, rd_valid_q, rvalid_q;
  logic [AW-1:0]         rd_addr_q;
  logic [2:0]            rd_prot_q;
  logic [DW-1:0]         rdata_q;
  resp_t                 rresp_q;
  logic                  ar_fire_s;

  // AW and W are tracked separately so they can land in either order or together.
  assign aw_fire_s = bus.awvalid & awready_q;
  assign w_fire_s  = bus.wvalid & wready_q;
  assign aw_have_s = aw_got_q | aw_fire_s;
  assign w_have_s  = w_got_q | w_fire_s;
  assign ar_fire_s = bus.arvalid & arready_q;

  // Write FSM next-state selection.
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE: if (aw_have_s && w_have_s) w_state_d = W_USER; else w_state_d = W_IDLE;
      W_USER: if (bus.wr_ready)          w_state_d = W_RESP; else w_state_d = W_USER;
      W_RESP: if (bus.bready)            w_state_d = W_IDLE; else w_state_d = W_RESP;
      default:                           w_state_d = W_IDLE;
    endcase
  end

  // Write path: capture AW/W, present to user, return the user's response on B.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state_q  <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      wr_valid_q <= 1'b0;
      bvalid_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_prot_q  <= 3'b000;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
      bresp_q    <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      case (w_state_q)
        W_IDLE: begin
          if (aw_fire_s) begin
            wr_addr_q <= bus.awaddr;
            wr_prot_q <= bus.awprot;
          end
          if (w_fire_s) begin
            wr_data_q <= bus.wdata;
            wr_strb_q <= bus.wstrb;
          end
          if (aw_have_s && w_have_s) begin
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            aw_got_q   <= 1'b0;
            w_got_q    <= 1'b0;
            wr_valid_q <= 1'b1;
          end else begin
            // Readys come up on the first edge out of reset and each drops after its own capture.
            awready_q <= ~aw_have_s;
            wready_q  <= ~w_have_s;
            aw_got_q  <= aw_have_s;
            w_got_q   <= w_have_s;
          end
        end
        W_USER: begin
          if (bus.wr_ready) begin
            bresp_q    <= resp_t'(bus.wr_resp);
            wr_valid_q <= 1'b0;
            bvalid_q   <= 1'b1;
          end
        end
        W_RESP: begin
          if (bus.bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: begin
          awready_q  <= 1'b0;
          wready_q   <= 1'b0;
          aw_got_q   <= 1'b0;
          w_got_q    <= 1'b0;
          wr_valid_q <= 1'b0;
          bvalid_q   <= 1'b0;
        end
      endcase
    end
  end

  // Read FSM next-state selection.
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE: if (ar_fire_s)    r_state_d = R_USER; else r_state_d = R_IDLE;
      R_USER: if (bus.rd_ready) r_state_d = R_RESP; else r_state_d = R_USER;
      R_RESP: if (bus.rready)   r_state_d = R_IDLE; else r_state_d = R_RESP;
      default:                  r_state_d = R_IDLE;
    endcase
  end

  // Read path: capture AR, present to user, return user data/response on R.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state_q  <= R_IDLE;
      arready_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rvalid_q   <= 1'b0;
      rd_addr_q  <= '0;
      rd_prot_q  <= 3'b000;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      case (r_state_q)
        R_IDLE: begin
          if (ar_fire_s) begin
            rd_addr_q  <= bus.araddr;
            rd_prot_q  <= bus.arprot;
            arready_q  <= 1'b0;
            rd_valid_q <= 1'b1;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_USER: begin
          if (bus.rd_ready) begin
            rdata_q    <= bus.rd_data;
            rresp_q    <= resp_t'(bus.rd_resp);
            rd_valid_q <= 1'b0;
            rvalid_q   <= 1'b1;
          end
        end
        R_RESP: begin
          if (bus.rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
          end
        end
        default: begin
          arready_q  <= 1'b0;
          rd_valid_q <= 1'b0;
          rvalid_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.awready  = awready_q;
  assign bus.wready   = wready_q;
  assign bus.bvalid   = bvalid_q;
  assign bus.bresp    = bresp_q;
  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_prot  = wr_prot_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.wr_strb  = wr_strb_q;
  assign bus.arready  = arready_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.rdata    = rdata_q;
  assign bus.rresp    = rresp_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.rd_prot  = rd_prot_q;

endmodule

// File: tb/tb_axi4_lite_slave_endpoint.sv
// Self-checking bench for axi4_lite_slave_endpoint: directed scenarios plus
// randomized write/read transactions. Each transaction's expected outputs come
// straight from the request the bench issued and the response it supplied.
module tb_axi4_lite_slave_endpoint;
  logic aclk;
  logic areset;
  int   n_chk  = 0;
  int   n_pass = 0;

  axi4_lite_slave_endpoint_if #(.DATA_BYTES(4), .ADDR_BYTES(1)) ifc ();

  axi4_lite_slave_endpoint #(.DATA_BYTES(4), .ADDR_BYTES(1)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (ifc)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle_inputs();
    ifc.awvalid = 1'b0; ifc.awaddr = 8'h00; ifc.awprot = 3'b000;
    ifc.wvalid  = 1'b0; ifc.wdata  = 32'h0; ifc.wstrb  = 4'h0;
    ifc.bready  = 1'b0;
    ifc.arvalid = 1'b0; ifc.araddr = 8'h00; ifc.arprot = 3'b000;
    ifc.rready  = 1'b0;
    ifc.wr_ready = 1'b0; ifc.wr_resp = 2'b00;
    ifc.rd_ready = 1'b0; ifc.rd_data = 32'h0; ifc.rd_resp = 2'b00;
  endtask

  // Every DUT output concatenated; all must be zero in reset.
  function automatic logic [63:0] all_outputs();
    return {ifc.awready, ifc.wready, ifc.bvalid, ifc.bresp, ifc.arready, ifc.rvalid, ifc.rresp,
            ifc.wr_valid, ifc.wr_prot, ifc.wr_strb, ifc.rd_valid, ifc.rd_prot,
            ifc.wr_addr, ifc.rd_addr};
  endfunction

  function automatic logic [63:0] all_data_outputs();
    return {ifc.rdata, ifc.wr_data};
  endfunction

  // One complete write: AW/W start offsets, user delay, B-channel backpressure.
  task automatic do_write(input logic [7:0] addr, input logic [2:0] prot, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] resp,
                          input int aw_start, input int w_start, input int u_dly, input int b_dly,
                          input bit abort_b);
    bit aw_pend = 0, w_pend = 0, aw_done = 0, w_done = 0;
    bit u_drv = 0, u_pend = 0, u_done = 0, b_drv = 0, b_pend = 0, b_done = 0;
    bit seen_wr = 0, seen_b = 0;
    int cyc = 0, u_wait = 0, b_wait = 0;
    while (!b_done && !(abort_b && seen_b) && cyc < 200) begin
      @(negedge aclk);
      if (aw_pend) begin ifc.awvalid = 1'b0; aw_done = 1; aw_pend = 0; end
      if (w_pend)  begin ifc.wvalid  = 1'b0; w_done  = 1; w_pend  = 0; end
      if (u_pend)  begin ifc.wr_ready = 1'b0; ifc.wr_resp = ~resp; u_done = 1; u_pend = 0; end
      if (b_pend)  begin ifc.bready = 1'b0; b_done = 1; b_pend = 0; end

      if (!seen_wr) begin
        if (aw_done && w_done) begin
          seen_wr = 1;
          chk("wr_valid_latency", ifc.wr_valid, 1'b1);
          chk("wr_payload", {ifc.wr_addr, ifc.wr_prot, ifc.wr_strb, ifc.wr_data},
              {addr, prot, strb, data});
        end else begin
          chk("wr_valid_early", ifc.wr_valid, 1'b0);
          if (aw_done) chk("awready_drop", ifc.awready, 1'b0);
          if (w_done)  chk("wready_drop", ifc.wready, 1'b0);
        end
      end

      if (seen_wr && !u_drv) begin
        if (u_wait >= u_dly) begin
          ifc.wr_ready = 1'b1; ifc.wr_resp = resp; u_drv = 1;
        end else begin
          chk("wr_hold", {ifc.wr_valid, ifc.wr_addr, ifc.wr_data}, {1'b1, addr, data});
          ifc.wr_resp = 2'(u_wait);
          u_wait++;
        end
      end
      if (u_drv && !u_done && !u_pend) u_pend = ifc.wr_valid && ifc.wr_ready;

      if (u_done && !seen_b) begin
        seen_b = 1;
        chk("b_latency", {ifc.bvalid, ifc.wr_valid}, 2'b10);
        chk("bresp", ifc.bresp, resp);
      end
      if (seen_b && !b_drv && !abort_b) begin
        if (b_wait >= b_dly) begin
          ifc.bready = 1'b1; b_drv = 1;
        end else begin
          chk("b_hold", {ifc.bvalid, ifc.bresp, ifc.awready, ifc.wready}, {1'b1, resp, 2'b00});
          b_wait++;
        end
      end
      if (b_drv && !b_done && !b_pend) b_pend = ifc.bvalid && ifc.bready;

      if (b_done) chk("b_done_idle", {ifc.bvalid, ifc.awready, ifc.wready}, 3'b011);

      if (!aw_done && !aw_pend && cyc >= aw_start) begin
        ifc.awvalid = 1'b1; ifc.awaddr = addr; ifc.awprot = prot;
      end
      if (!w_done && !w_pend && cyc >= w_start) begin
        ifc.wvalid = 1'b1; ifc.wdata = data; ifc.wstrb = strb;
      end
      if (ifc.awvalid && !aw_pend) aw_pend = ifc.awready;
      if (ifc.wvalid && !w_pend)   w_pend  = ifc.wready;
      cyc++;
    end
    if (!b_done && !(abort_b && seen_b)) chk("wr_timeout", 1'b0, 1'b1);
  endtask

  // One complete read: AR start offset, user delay, R-channel backpressure.
  task automatic do_read(input logic [7:0] addr, input logic [2:0] prot, input logic [31:0] data,
                         input logic [1:0] resp, input int ar_start, input int u_dly, input int r_dly);
    bit ar_pend = 0, ar_done = 0, u_drv = 0, u_pend = 0, u_done = 0;
    bit r_drv = 0, r_pend = 0, r_done = 0, seen_rd = 0, seen_r = 0;
    int cyc = 0, u_wait = 0, r_wait = 0;
    while (!r_done && cyc < 200) begin
      @(negedge aclk);
      if (ar_pend) begin ifc.arvalid = 1'b0; ar_done = 1; ar_pend = 0; end
      if (u_pend)  begin ifc.rd_ready = 1'b0; ifc.rd_data = ~data; ifc.rd_resp = ~resp; u_done = 1; u_pend = 0; end
      if (r_pend)  begin ifc.rready = 1'b0; r_done = 1; r_pend = 0; end

      if (!seen_rd) begin
        if (ar_done) begin
          seen_rd = 1;
          chk("rd_valid_latency", {ifc.rd_valid, ifc.arready}, 2'b10);
          chk("rd_payload", {ifc.rd_addr, ifc.rd_prot}, {addr, prot});
        end else begin
          chk("rd_valid_early", ifc.rd_valid, 1'b0);
        end
      end

      if (seen_rd && !u_drv) begin
        if (u_wait >= u_dly) begin
          ifc.rd_ready = 1'b1; ifc.rd_data = data; ifc.rd_resp = resp; u_drv = 1;
        end else begin
          chk("rd_hold", {ifc.rd_valid, ifc.rd_addr, ifc.rvalid}, {1'b1, addr, 1'b0});
          ifc.rd_data = $urandom;
          u_wait++;
        end
      end
      if (u_drv && !u_done && !u_pend) u_pend = ifc.rd_valid && ifc.rd_ready;

      if (u_done && !seen_r) begin
        seen_r = 1;
        chk("r_latency", {ifc.rvalid, ifc.rd_valid}, 2'b10);
        chk("rdata_rresp", {ifc.rdata, ifc.rresp}, {data, resp});
      end
      if (seen_r && !r_drv) begin
        if (r_wait >= r_dly) begin
          ifc.rready = 1'b1; r_drv = 1;
        end else begin
          chk("r_hold", {ifc.rvalid, ifc.rdata, ifc.rresp, ifc.arready}, {1'b1, data, resp, 1'b0});
          r_wait++;
        end
      end
      if (r_drv && !r_done && !r_pend) r_pend = ifc.rvalid && ifc.rready;

      if (r_done) chk("r_done_idle", {ifc.rvalid, ifc.arready}, 2'b01);

      if (!ar_done && !ar_pend && cyc >= ar_start) begin
        ifc.arvalid = 1'b1; ifc.araddr = addr; ifc.arprot = prot;
      end
      if (ifc.arvalid && !ar_pend) ar_pend = ifc.arready;
      cyc++;
    end
    if (!r_done) chk("rd_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    idle_inputs();
    areset = 1'b1;
    repeat (3) @(negedge aclk);
    chk("reset_outputs", all_outputs(), 64'h0);
    chk("reset_data", all_data_outputs(), 64'h0);
    areset = 1'b0;
    @(negedge aclk);
    chk("ready_after_reset", {ifc.awready, ifc.wready, ifc.arready}, 3'b111);

    // 1: AW and W together, EXOKAY response
    do_write(8'hC4, 3'b000, 32'hDEADBEEF, 4'hF, 2'b01, 0, 0, 0, 0, 1'b0);
    // 2: read with OKAY
    do_read(8'hC4, 3'b000, 32'h0000ABCD, 2'b00, 0, 0, 0);
    // 3: W three cycles ahead of AW, partial strobe
    do_write(8'h10, 3'b010, 32'h12345678, 4'h5, 2'b10, 3, 0, 1, 0, 1'b0);
    // AW ahead of W
    do_write(8'h20, 3'b001, 32'hCAFEF00D, 4'h3, 2'b11, 0, 2, 0, 0, 1'b0);
    // 4: B and R backpressure for 5 cycles
    do_write(8'h44, 3'b111, 32'hA5A5A5A5, 4'h9, 2'b00, 0, 0, 2, 5, 1'b0);
    do_read(8'h88, 3'b101, 32'h5A5A5A5A, 2'b11, 0, 2, 5);
    // 5: write and read launched on the same cycle
    fork
      do_write(8'h3C, 3'b011, 32'h0BADCAFE, 4'hE, 2'b01, 0, 0, 1, 2, 1'b0);
      do_read(8'hF0, 3'b100, 32'h87654321, 2'b10, 0, 3, 1);
    join

    // randomized traffic: write only, read only, or both concurrently
    for (int i = 0; i < 24; i++) begin
      int kind;
      logic [7:0]  wa, ra;
      logic [31:0] wd, rdv;
      logic [3:0]  ws;
      logic [2:0]  wp, rp;
      logic [1:0]  wrs, rrs;
      kind = $urandom_range(0, 2);
      wa = 8'($urandom); ra = 8'($urandom); wd = $urandom; rdv = $urandom;
      ws = 4'($urandom); wp = 3'($urandom); rp = 3'($urandom);
      wrs = 2'($urandom); rrs = 2'($urandom);
      if (kind == 0) begin
        do_write(wa, wp, wd, ws, wrs, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
      end else if (kind == 1) begin
        do_read(ra, rp, rdv, rrs, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      end else begin
        fork
          do_write(wa, wp, wd, ws, wrs, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
          do_read(ra, rp, rdv, rrs, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        join
      end
    end

    // 6: reset while bvalid is high, read in flight on user side
    fork
      do_write(8'h77, 3'b110, 32'hFEEDFACE, 4'hF, 2'b10, 0, 0, 0, 0, 1'b1);
      begin
        @(negedge aclk);
        ifc.arvalid = 1'b1; ifc.araddr = 8'h99; ifc.arprot = 3'b001;
        @(negedge aclk);
        ifc.arvalid = 1'b0;
      end
    join
    chk("pre_reset_bvalid", {ifc.bvalid, ifc.rd_valid}, 2'b11);
    #2;
    areset = 1'b1;
    idle_inputs();
    #1;
    chk("async_reset_outputs", all_outputs(), 64'h0);
    chk("async_reset_data", all_data_outputs(), 64'h0);
    repeat (2) @(negedge aclk);
    chk("held_reset_outputs", all_outputs(), 64'h0);
    areset = 1'b0;
    @(negedge aclk);
    chk("ready_after_rerelease", {ifc.awready, ifc.wready, ifc.arready, ifc.bvalid, ifc.rd_valid},
        5'b11100);
    do_write(8'h5E, 3'b000, 32'h0F0F0F0F, 4'hC, 2'b00, 0, 1, 0, 0, 1'b0);
    do_read(8'h5E, 3'b010, 32'h13572468, 2'b01, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
